// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-chain definitions.
// - Default FFT / cyclic-prefix sizes.
// - I/Q packing helper: bit offset of a channel's I or Q component within a stream beat
//   (ch0 I at the LSB, then ch0 Q, ch1 I, ch1 Q, ...).
// - CP-removal window state type.
package ofdm_pkg;

    localparam int unsigned FFT_SIZE_DEF = 64;
    localparam int unsigned CP_LEN_DEF   = 16;

    typedef enum logic [1:0] {
        SKIP_HEAD = 2'd0,
        PASS      = 2'd1,
        SKIP_TAIL = 2'd2
    } cp_state_t;

    // LSB position of component (ch, is_q) for components of 'width' bits.
    function automatic int unsigned iq_offset(input int unsigned width, input int unsigned ch,
                                              input bit is_q);
        return (2 * ch + (is_q ? 1 : 0)) * width;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-stage AXI4-Stream output register carrying data, last and user.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   load_i           capture data_i/last_i/user_i and assert valid_o
//   data_i/last_i/user_i  beat to capture
//   ready_i          downstream ready; clears valid_o when nothing new is loaded
//   valid_o/data_o/last_o/user_o  registered stream outputs
// The caller only asserts load_i when the register is empty or being drained, so the
// held beat is never overwritten while stalled.
module axis_out_reg #(
    parameter int unsigned DataWidth = 48
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 last_i,
    input  logic                 user_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 last_o,
    output logic                 user_o
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic                 user_q, user_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        user_d  = user_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
            user_d  = user_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

endmodule

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops CP_LEN samples per OFDM symbol and forwards FFT_SIZE
// samples framed with tuser (window start) and tlast (window end). cp_backoff shifts the
// window that many samples into the CP; it is clamped to CP_LEN and latched per symbol.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_axis_*                         CFO-corrected I/Q input stream
//   m_axis_*                         windowed output stream (bit-exact input samples)
//   cp_backoff                       CP samples kept ahead of the FFT window
//   symbol_idx                       index within the frame of the symbol being input
//   err_trunc                        one-cycle pulse after a frame ended mid-symbol
module cp_remover
    import ofdm_pkg::*;
#(
    parameter int unsigned WIDTH           = 12,
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned AXIS_DATA_WIDTH = NUM_CHANNELS * 2 * WIDTH,
    parameter int unsigned FFT_SIZE        = FFT_SIZE_DEF,
    parameter int unsigned CP_LEN          = CP_LEN_DEF,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic [$clog2(CP_LEN+1)-1:0]  cp_backoff,
    output logic [CNT_WIDTH-1:0]         symbol_idx,
    output logic                         err_trunc
);

    localparam int unsigned BW = $clog2(CP_LEN + 1);
    localparam int unsigned CW = $clog2(FFT_SIZE + CP_LEN);
    localparam logic [CW-1:0] FftLast = CW'(FFT_SIZE - 1);
    localparam logic [BW-1:0] CpLenBo = BW'(CP_LEN);

    cp_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bo_q, bo_d;
    logic [CNT_WIDTH-1:0] symbol_idx_q, symbol_idx_d;
    logic                 err_q, err_d;

    logic [BW-1:0] eff_bo_in;
    logic [BW-1:0] bo_cur;
    logic [CW-1:0] head_len;
    logic          sym_first;
    logic          head_pass;
    logic          pass_beat;
    logic          accept;
    logic          sym_end;
    logic          out_valid;
    logic          out_user;
    logic          out_last;

    assign eff_bo_in = (cp_backoff > CpLenBo) ? CpLenBo : cp_backoff;
    assign sym_first = (state_q == SKIP_HEAD) && (cnt_q == '0);
    // The first beat of a symbol sees the live backoff; later head beats the latched one.
    assign bo_cur    = sym_first ? eff_bo_in : bo_q;
    assign head_len  = CW'(CP_LEN) - CW'(bo_cur);
    // Full backoff: the first beat of the symbol is already PASS beat 0.
    assign head_pass = (state_q == SKIP_HEAD) && (head_len == '0);
    assign pass_beat = (state_q == PASS) || head_pass;

    // Only beats that would be forwarded can be held back by the output register.
    assign s_axis_tready = !pass_beat || m_axis_tready || !out_valid;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign out_user = head_pass || ((state_q == PASS) && (cnt_q == '0));
    // An early input tlast on a forwarded beat closes the truncated window.
    assign out_last = ((state_q == PASS) && (cnt_q == FftLast)) || s_axis_tlast;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bo_d         = bo_q;
        symbol_idx_d = symbol_idx_q;
        err_d        = 1'b0;
        sym_end      = 1'b0;
        if (accept) begin
            if (sym_first) begin
                bo_d = eff_bo_in;
            end
            unique case (state_q)
                SKIP_HEAD: begin
                    if (head_pass) begin
                        state_d = PASS;
                        cnt_d   = CW'(1);
                    end else if (cnt_q == head_len - CW'(1)) begin
                        state_d = PASS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PASS: begin
                    if (cnt_q == FftLast) begin
                        cnt_d = '0;
                        if (bo_q == '0) begin
                            state_d = SKIP_HEAD;
                            sym_end = 1'b1;
                        end else begin
                            state_d = SKIP_TAIL;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SKIP_TAIL: begin
                    if (cnt_q == CW'(bo_q) - CW'(1)) begin
                        state_d = SKIP_HEAD;
                        cnt_d   = '0;
                        sym_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = SKIP_HEAD;
                    cnt_d   = '0;
                end
            endcase
            if (s_axis_tlast) begin
                state_d      = SKIP_HEAD;
                cnt_d        = '0;
                symbol_idx_d = '0;
                err_d        = !sym_end;
            end else if (sym_end) begin
                symbol_idx_d = symbol_idx_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SKIP_HEAD;
            cnt_q        <= '0;
            bo_q         <= '0;
            symbol_idx_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bo_q         <= bo_d;
            symbol_idx_q <= symbol_idx_d;
            err_q        <= err_d;
        end
    end

    axis_out_reg #(
        .DataWidth(AXIS_DATA_WIDTH)
    ) u_out_reg (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (accept && pass_beat),
        .data_i (s_axis_tdata),
        .last_i (out_last),
        .user_i (out_user),
        .ready_i(m_axis_tready),
        .valid_o(out_valid),
        .data_o (m_axis_tdata),
        .last_o (m_axis_tlast),
        .user_o (m_axis_tuser)
    );

    assign m_axis_tvalid = out_valid;
    assign symbol_idx    = symbol_idx_q;
    assign err_trunc     = err_q;

endmodule

// File: tb/tb_cp_remover.sv
// Self-checking bench for cp_remover: table of frame scenarios checked against a
// position-based windowing model, plus a hand-written mid-symbol reset sequence.
module tb_cp_remover;
    import ofdm_pkg::*;

    localparam int unsigned W   = 12;
    localparam int unsigned DW  = 48;
    localparam int          FFT = 64;
    localparam int          CP  = 16;
    localparam int          SYM = FFT + CP;
    localparam int unsigned BOW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic [BOW-1:0] cp_backoff = '0;
    logic [15:0]   symbol_idx;
    logic          err_trunc;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int seq = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        int bo;
        int len1;
        int len2;
        int gap;
        bit rnd;
        int exp_cnt;
        int first_off;
        int exp_err;
    } vec_t;

    beat_t cap_q[$];
    beat_t exp_q[$];
    vec_t  vecs[6];

    cp_remover dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .cp_backoff   (cp_backoff),
        .symbol_idx   (symbol_idx),
        .err_trunc    (err_trunc)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input int s);
        logic [DW-1:0] d;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        d  = '0;
        lo = W'(s);
        hi = W'(s >> 12);
        d[iq_offset(W, 0, 1'b0) +: W] = lo;
        d[iq_offset(W, 0, 1'b1) +: W] = hi;
        d[iq_offset(W, 1, 1'b0) +: W] = ~lo;
        d[iq_offset(W, 1, 1'b1) +: W] = lo ^ 12'hA5A;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: captures transfers, counts error pulses, checks hold while stalled.
    initial begin : monitor
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        prev_stall = 1'b0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            if (err_trunc) err_seen++;
            if (prev_stall) begin
                chk("stall_valid", 64'(m_tvalid), 64'd1);
                chk("stall_data", 64'(m_tdata), 64'(prev_d));
            end
            if (m_tvalid && m_tready) cap_q.push_back('{m_tdata, m_tlast, m_tuser});
            prev_stall = !rst && m_tvalid && !m_tready;
            prev_d     = m_tdata;
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) m_tready = 1'($urandom_range(1));
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic last, input int gap_pct, input int exp_idx,
                        input logic [BOW-1:0] bo);
        int budget;
        budget = 0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tdata    = mk(seq);
        s_tlast    = last;
        s_tvalid   = 1'b1;
        cp_backoff = bo;
        @(negedge clk);
        if (exp_idx >= 0) chk("symbol_idx", 64'(symbol_idx), 64'(exp_idx));
        while (!s_tready && budget < 2000) begin
            budget++;
            @(negedge clk);
        end
        if (!s_tready) chk("accept_timeout", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        seq++;
    endtask

    // Model: sample at symbol position q is forwarded iff it lies in the shifted window.
    task automatic send_frame(input int len, input int bo, input int gap_pct, input bit jitter);
        int boe;
        int lo;
        int q;
        logic [BOW-1:0] bo_drv;
        boe = (bo > CP) ? CP : bo;
        lo  = CP - boe;
        for (int p = 0; p < len; p++) begin
            q = p % SYM;
            if (q >= lo && q < lo + FFT)
                exp_q.push_back('{mk(seq), (q == lo + FFT - 1) || (p == len - 1), q == lo});
            bo_drv = (jitter && q != 0) ? BOW'($urandom_range(31)) : BOW'(bo);
            send(p == len - 1, gap_pct, (q == 0) ? p / SYM : -1, bo_drv);
        end
    endtask

    task automatic compare_run(input int exp_cnt, input int first_seq, input int exp_err);
        int n;
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        repeat (4) @(negedge clk);
        chk("out_count", 64'(cap_q.size()), 64'(exp_cnt));
        chk("model_count", 64'(cap_q.size()), 64'(exp_q.size()));
        if (cap_q.size() > 0) chk("first_data", 64'(cap_q[0].d), 64'(mk(first_seq)));
        chk("err_pulses", 64'(err_seen), 64'(exp_err));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk("out_beat", 64'({cap_q[i].last, cap_q[i].user, cap_q[i].d}),
                64'({exp_q[i].last, exp_q[i].user, exp_q[i].d}));
    endtask

    initial begin : main
        int base;
        vecs[0] = '{bo: 0,  len1: 240,  len2: 0,  gap: 0,  rnd: 0, exp_cnt: 192,  first_off: 16,
                    exp_err: 0};
        vecs[1] = '{bo: 4,  len1: 80,   len2: 0,  gap: 0,  rnd: 0, exp_cnt: 64,   first_off: 12,
                    exp_err: 0};
        vecs[2] = '{bo: 20, len1: 80,   len2: 0,  gap: 0,  rnd: 0, exp_cnt: 64,   first_off: 0,
                    exp_err: 0};
        vecs[3] = '{bo: 0,  len1: 121,  len2: 80, gap: 0,  rnd: 0, exp_cnt: 153,  first_off: 16,
                    exp_err: 1};
        vecs[4] = '{bo: 0,  len1: 6,    len2: 80, gap: 0,  rnd: 0, exp_cnt: 64,   first_off: 22,
                    exp_err: 1};
        vecs[5] = '{bo: 4,  len1: 8000, len2: 0,  gap: 30, rnd: 1, exp_cnt: 6400, first_off: 12,
                    exp_err: 0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tuser", 64'(m_tuser), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_symbol_idx", 64'(symbol_idx), 64'd0);
        chk("rst_err", 64'(err_trunc), 64'd0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            cap_q.delete();
            exp_q.delete();
            err_seen   = 0;
            base       = seq;
            rand_ready = vecs[v].rnd;
            send_frame(vecs[v].len1, vecs[v].bo, vecs[v].gap, vecs[v].rnd);
            chk("frame_end_idx", 64'(symbol_idx), 64'd0);
            if (vecs[v].len2 > 0) send_frame(vecs[v].len2, vecs[v].bo, vecs[v].gap, vecs[v].rnd);
            compare_run(vecs[v].exp_cnt, base + vecs[v].first_off, vecs[v].exp_err);
        end

        // Reset at beat 50 with a beat held in the output register.
        do_reset();
        for (int p = 0; p < 50; p++) send(1'b0, 0, -1, BOW'(0));
        m_tready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", 64'(m_tvalid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
        chk("mid_rst_tuser", 64'(m_tuser), 64'd0);
        chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
        chk("mid_rst_symbol_idx", 64'(symbol_idx), 64'd0);
        chk("mid_rst_err", 64'(err_trunc), 64'd0);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        cap_q.delete();
        exp_q.delete();
        err_seen = 0;
        base     = seq;
        send_frame(80, 0, 0, 1'b0);
        compare_run(64, base + 16, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
